// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory engine (mem_access_unit):
// memCode values, FSM state type, address-exception codes and code decoders.
package mem_pkg;

  localparam logic [3:0] MC_LW  = 4'b0000;
  localparam logic [3:0] MC_SW  = 4'b0001;
  localparam logic [3:0] MC_LH  = 4'b0010;
  localparam logic [3:0] MC_LB  = 4'b0011;
  localparam logic [3:0] MC_LHU = 4'b0100;
  localparam logic [3:0] MC_LBU = 4'b0101;
  localparam logic [3:0] MC_SH  = 4'b0110;
  localparam logic [3:0] MC_SB  = 4'b0111;
  localparam logic [3:0] MC_NO  = 4'b1000;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} mem_state_t;

  // Every code with bit 3 set (1000..1111) behaves as "no access".
  function automatic logic is_active(input logic [3:0] code);
    return ~code[3];
  endfunction

  function automatic logic is_store(input logic [3:0] code);
    return (code == MC_SW) || (code == MC_SH) || (code == MC_SB);
  endfunction

  function automatic logic is_load(input logic [3:0] code);
    return is_active(code) && !is_store(code);
  endfunction

  // Misaligned word/half access, or any address bit above the RAM range set.
  function automatic logic addr_error(input logic [3:0] code, input logic [31:0] addr,
                                      input int addr_w);
    logic misaligned;
    case (code)
      MC_LW, MC_SW:         misaligned = (addr[1:0] != 2'b00);
      MC_LH, MC_LHU, MC_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    return misaligned || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus between the EX/MEM pipeline register and the data-memory engine.
// Handshake: mem_code other than a no-op is the request-valid; stall is the
// inverse of ready. The request is taken in the first cycle it is seen in
// IDLE and must be held stable until stall falls; the cycle after stall
// falls carries the finished instruction and is never taken again.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic [3:0]  mem_code;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        exc;
  logic [4:0]  exc_code;
  mem_state_t  state;

  modport master (output mem_code, addr, wdata,
                  input  stall, rdata, rdata_valid, exc, exc_code, state);
  modport slave  (input  mem_code, addr, wdata,
                  output stall, rdata, rdata_valid, exc, exc_code, state);
endinterface

// File: rtl/mem_load_ext.sv
// Load lane selection and sign/zero extension for the data-memory engine.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [3:0]  code,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  bsel;

  assign half = lane[1] ? word[31:16] : word[15:0];

  // Pick the addressed byte, then extend according to the load flavour.
  always_comb begin
    bsel = word[7:0];
    case (lane)
      2'd1:    bsel = word[15:8];
      2'd2:    bsel = word[23:16];
      2'd3:    bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
    result = word;
    case (code)
      MC_LH:   result = {{16{half[15]}}, half};
      MC_LHU:  result = {16'd0, half};
      MC_LB:   result = {{24{bsel[7]}}, bsel};
      MC_LBU:  result = {24'd0, bsel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory engine: byte-lane stores and extended loads on a
// word RAM with a fixed access latency, stalling the pipeline meanwhile.
// Optional feature macro: ADDR_EXC_EN (address exceptions AdEL/AdES).
// LATENCY must lie in 1..15.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  mem_state_t        state;
  logic [3:0]        cnt;
  logic [3:0]        code_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              rdata_valid_q;
  logic              exc_q;
  logic [4:0]        exc_code_q;

  logic [31:0]       ram [DEPTH];

  logic              accept;
  logic              commit;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       st_data;
  logic [31:0]       ld_val;
  logic [ADDR_W-1:0] idx;

  // No request is taken while reset is held, so stall stays low then too.
  assign accept = rst_n && (state == S_IDLE) && is_active(bus.mem_code);
  assign commit = (state == S_WAIT) && (cnt == 4'd0);
  assign idx    = addr_q[ADDR_W+1:2];

`ifdef ADDR_EXC_EN
  assign acc_err = addr_error(bus.mem_code, bus.addr, ADDR_W);
`else
  // Upper address bits are ignored; the word index wraps over the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
  assign acc_err = 1'b0;
`endif

  // Store byte enables with the store data replicated across all lanes.
  always_comb begin
    be      = 4'b0000;
    st_data = wdata_q;
    case (code_q)
      MC_SW: be = 4'b1111;
      MC_SH: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      MC_SB: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  // RAM write at the commit edge; be is all-zero for loads.
  always_ff @(posedge clk) begin
    if (rst_n && commit && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  mem_load_ext u_load_ext (
    .code   (code_q),
    .lane   (addr_q[1:0]),
    .word   (ram[idx]),
    .result (ld_val)
  );

  // Access FSM: accept in IDLE, count down in WAIT, report in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      code_q        <= MC_NO;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      err_q         <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      exc_q         <= 1'b0;
      exc_code_q    <= 5'd0;
    end else begin
      rdata_valid_q <= 1'b0;
      exc_q         <= 1'b0;
      exc_code_q    <= 5'd0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            code_q  <= bus.mem_code;
            addr_q  <= bus.addr[ADDR_W+1:0];
            wdata_q <= bus.wdata;
            err_q   <= acc_err;
            cnt     <= 4'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_DONE;
            if (err_q) begin
              rdata_q    <= 32'd0;
              exc_q      <= 1'b1;
              exc_code_q <= is_load(code_q) ? EXC_ADEL : EXC_ADES;
            end else if (is_load(code_q)) begin
              rdata_q       <= ld_val;
              rdata_valid_q <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall       = accept || (state == S_WAIT);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.exc         = exc_q;
  assign bus.exc_code    = exc_code_q;
  assign bus.state       = state;

endmodule
